// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with write-to-read bypass and a
// hardware clear sequencer that zeroes every entry after reset and on request.
//
// Ports:
//   clk, rst_n         single rising-edge clock, asynchronous active-low reset
//   we, waddr, wdata   write port (ignored while busy)
//   re_a, raddr_a      read port A request; rdata_a registered, 1-cycle latency
//   re_b, raddr_b      read port B request; rdata_b registered, 1-cycle latency
//   clr                bulk clear request, level sampled in IDLE
//   busy               clear sequencer active (registered)
module regfile_2r1w #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              clr,
  output logic              busy
);

  localparam int unsigned       DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_ok;
  logic [WIDTH-1:0]  rd_a_nxt;
  logic [WIDTH-1:0]  rd_b_nxt;

  // Clear sequencer state and pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next state: CLEAR walks ptr through every entry once; clr is only heard in IDLE.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        ptr_nxt = ptr + ADDR_W'(1);
        if (ptr == LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Read data selection: zero while clearing, bypass on same-edge write hit.
  always_comb begin
    wr_ok    = (state == IDLE) && we;
    rd_a_nxt = rdata_a;
    rd_b_nxt = rdata_b;
    if (re_a) begin
      if (state == CLEAR)                 rd_a_nxt = '0;
      else if (wr_ok && raddr_a == waddr) rd_a_nxt = wdata;
      else                                rd_a_nxt = mem[raddr_a];
    end
    if (re_b) begin
      if (state == CLEAR)                 rd_b_nxt = '0;
      else if (wr_ok && raddr_b == waddr) rd_b_nxt = wdata;
      else                                rd_b_nxt = mem[raddr_b];
    end
  end

  // Registered outputs; busy tracks the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
      busy    <= 1'b1;
    end else begin
      rdata_a <= rd_a_nxt;
      rdata_b <= rd_b_nxt;
      busy    <= (state_nxt == CLEAR);
    end
  end

  // Storage has no reset so it can map onto a RAM; the sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w (WIDTH=16, ADDR_W=4).
// Stimulus queues the hand-computed result of each edge; a monitor pops and
// compares on the following falling edge.
module tb_regfile_2r1w;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic          re_a;
  logic [AW-1:0] raddr_a;
  logic [W-1:0]  rdata_a;
  logic          re_b;
  logic [AW-1:0] raddr_b;
  logic [W-1:0]  rdata_b;
  logic          clr;
  logic          busy;

  always #5 clk = ~clk;

  regfile_2r1w #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re_a    (re_a),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a),
    .re_b    (re_b),
    .raddr_b (raddr_b),
    .rdata_b (rdata_b),
    .clr     (clr),
    .busy    (busy)
  );

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic         qy[$];
  logic chk_a = 1'b0, chk_b = 1'b0, chk_y = 1'b0;
  logic vld_a = 1'b0, vld_b = 1'b0, vld_y = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic cmp(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (vec %0d): got %h, expected %h", name, n_vec, got, exp);
    end
  endtask

  task automatic miss(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (vec %0d): output seen with no expected value queued", name, n_vec);
  endtask

  // Marks which outputs the last edge produced something to check.
  always @(posedge clk) begin
    vld_a <= chk_a;
    vld_b <= chk_b;
    vld_y <= chk_y;
  end

  // Monitor: compare registered outputs against the scoreboard.
  always @(negedge clk) begin
    if (vld_a) begin
      if (qa.size() == 0) miss("rdata_a");
      else cmp("rdata_a", rdata_a, qa.pop_front());
    end
    if (vld_b) begin
      if (qb.size() == 0) miss("rdata_b");
      else cmp("rdata_b", rdata_b, qb.pop_front());
    end
    if (vld_y) begin
      if (qy.size() == 0) miss("busy");
      else cmp("busy", W'(busy), W'(qy.pop_front()));
    end
  end

  // One clock edge of stimulus plus the expected outputs after that edge.
  task automatic step(input logic w, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                      input logic ea, input logic [AW-1:0] ra,
                      input logic eb, input logic [AW-1:0] rb,
                      input logic c,
                      input logic ca, input logic [W-1:0] xa,
                      input logic cb, input logic [W-1:0] xb,
                      input logic cy, input logic xy);
    we = w; waddr = wa; wdata = wd;
    re_a = ea; raddr_a = ra;
    re_b = eb; raddr_b = rb;
    clr = c;
    chk_a = ca; chk_b = cb; chk_y = cy;
    if (ca) qa.push_back(xa);
    if (cb) qb.push_back(xb);
    if (cy) qy.push_back(xy);
    @(negedge clk);
  endtask

  task automatic rd(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                    input logic [W-1:0] xa, input logic [W-1:0] xb);
    step(1'b0, '0, '0, 1'b1, ra, 1'b1, rb, 1'b0, 1'b1, xa, 1'b1, xb, 1'b1, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] wa, input logic [W-1:0] wd);
    step(1'b1, wa, wd, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic quiet();
    we = 1'b0; waddr = '0; wdata = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0; clr = 1'b0;
    chk_a = 1'b0; chk_b = 1'b0; chk_y = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    quiet();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmp("reset rdata_a", rdata_a, 16'h0000);
    cmp("reset rdata_b", rdata_b, 16'h0000);
    cmp("reset busy", W'(busy), 16'h0001);
    rst_n = 1'b1;

    // Initial clear: 16 busy edges; writes of FFFF ignored, reads return 0.
    for (int i = 0; i < 16; i++)
      step(1'b1, AW'(i), 16'hFFFF, 1'b1, AW'(i), 1'b1, AW'(15 - i), 1'b0,
           1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, (i < 15));
    for (int i = 0; i < 16; i++) rd(AW'(i), AW'(15 - i), 16'h0000, 16'h0000);

    // Write then read on A; B holds with re_b=0.
    step(1'b1, 4'd3, 16'hA5A5, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 4'd3, 1'b0, '0, 1'b0, 1'b1, 16'hA5A5, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Dual-port bypass on entry 7, then plain read of the new value.
    wr(4'd7, 16'h1111);
    step(1'b1, 4'd7, 16'h2222, 1'b1, 4'd7, 1'b1, 4'd7, 1'b0, 1'b1, 16'h2222, 1'b1, 16'h2222, 1'b1, 1'b0);
    rd(4'd7, 4'd7, 16'h2222, 16'h2222);

    // Independent dual read, hold, single-port bypass.
    wr(4'd1, 16'h0001);
    wr(4'd14, 16'hBEEF);
    rd(4'd1, 4'd14, 16'h0001, 16'hBEEF);
    step(1'b0, '0, '0, 1'b0, 4'd3, 1'b0, 4'd7, 1'b0, 1'b1, 16'h0001, 1'b1, 16'hBEEF, 1'b1, 1'b0);
    step(1'b1, 4'd5, 16'h5A5A, 1'b1, 4'd5, 1'b1, 4'd14, 1'b0, 1'b1, 16'h5A5A, 1'b1, 16'hBEEF, 1'b1, 1'b0);
    rd(4'd3, 4'd5, 16'hA5A5, 16'h5A5A);

    // Fill with FFFF, then clr with a same-edge write+bypass that the clear erases.
    for (int i = 0; i < 16; i++) wr(AW'(i), 16'hFFFF);
    rd(4'd0, 4'd15, 16'hFFFF, 16'hFFFF);
    step(1'b1, 4'd0, 16'h1234, 1'b1, 4'd0, 1'b1, 4'd9, 1'b1, 1'b1, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    for (int j = 1; j <= 16; j++)
      step(1'b1, AW'(j - 1), 16'hFFFF, 1'b1, AW'(j - 1), 1'b1, AW'(16 - j), (j == 5),
           1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, (j < 16));
    for (int i = 0; i < 16; i++) rd(AW'(i), AW'(15 - i), 16'h0000, 16'h0000);

    // Asynchronous reset in the middle of a clear.
    wr(4'd9, 16'hBEEF);
    rd(4'd9, 4'd9, 16'hBEEF, 16'hBEEF);
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1, 1'b1);
    for (int j = 1; j <= 4; j++)
      step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1, 1'b1);
    quiet();
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async reset rdata_a", rdata_a, 16'h0000);
    cmp("async reset rdata_b", rdata_b, 16'h0000);
    cmp("async reset busy", W'(busy), 16'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++)
      step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, (i < 15));
    for (int i = 0; i < 16; i++) rd(AW'(i), AW'(15 - i), 16'h0000, 16'h0000);

    quiet();
    @(negedge clk);
    #1;
    cmp("scoreboard A drained", W'(qa.size()), 16'h0000);
    cmp("scoreboard B drained", W'(qb.size()), 16'h0000);
    cmp("scoreboard busy drained", W'(qy.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
